// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg -- shared definitions for the sequential divider.
//   DIV_W        default operand/result width
//   cnt_width()  iteration counter width for a given operand width
//   div_state_e  FSM state encoding (IDLE / CALC / FIN)
package seq_divider_pkg;

  localparam int DIV_W = 32;

  // Counter has to hold 0..WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step -- one combinational restoring shift-subtract iteration.
//   rem_i     partial remainder in (always < dvs_i)
//   dvd_bit_i next dividend bit shifted into the remainder
//   dvs_i     divisor (magnitude)
//   rem_o     next partial remainder
//   q_bit_o   quotient bit produced by this step
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  // The shifted remainder needs WIDTH+1 bits; one more bit catches the borrow.
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   shifted;

  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    trial   = {1'b0, shifted} - {2'b00, dvs_i};
    q_bit_o = ~trial[WIDTH+1];
    // On success the difference is below the divisor, so it fits WIDTH bits.
    rem_o   = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider -- multi-cycle restoring divider, one quotient bit per clock.
//   clk, reset        clock, synchronous active-high reset
//   start             request (taken in IDLE, and in FIN so a new request
//                     can be issued in the done cycle)
//   signed_op, A, B   operation mode, dividend, divisor (sampled with start)
//   busy              high while iterating
//   done              one-cycle pulse, Q/R/div_by_zero valid from then on
//   Q, R, div_by_zero results, held until the next completion
// Build option: define SEQ_DIVIDER_SIGNED_EN for signed (truncating) division;
// without it signed_op is ignored and everything is unsigned.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_nxt, raw_q, q_fin, r_fin;
  logic             q_bit;

  // FIN always returns to IDLE, so a request seen in FIN is handled exactly
  // as IDLE would; this is what lets a new start ride on the done cycle.
  assign accept = start && (state_q == ST_IDLE || state_q == ST_FIN);
  assign b_zero = (B == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .dvd_bit_i(quo_q[WIDTH-1]),
    .dvs_i    (dvs_q),
    .rem_o    (rem_nxt),
    .q_bit_o  (q_bit)
  );

  assign raw_q = {quo_q[WIDTH-2:0], q_bit};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic a_neg, b_neg;

  // Iterate on magnitudes; fix signs on the way out (truncation toward zero).
  // most-negative / -1 lands on magnitude 2^(W-1), whose negation is itself.
  always_comb begin
    a_neg   = signed_op & A[WIDTH-1];
    b_neg   = signed_op & B[WIDTH-1];
    a_mag   = a_neg ? -A : A;
    b_mag   = b_neg ? -B : B;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if (accept) begin
      neg_q_d = a_neg ^ b_neg;
      neg_r_d = a_neg;
    end
    q_fin = neg_q_q ? -raw_q : raw_q;
    r_fin = neg_r_q ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign a_mag = A;
  assign b_mag = B;
  assign q_fin = raw_q;
  assign r_fin = rem_nxt;
`endif

  // State register plus datapath/output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = b_zero ? ST_FIN : ST_CALC;
      ST_CALC: if (cnt_q == LAST) state_d = ST_FIN;
      ST_FIN:  state_d = accept ? (b_zero ? ST_FIN : ST_CALC) : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and outputs. Outputs are registered from the next state, so
  // results are loaded on the edge entering FIN and are valid with done.
  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    q_d    = q_q;
    r_d    = r_q;
    dbz_d  = dbz_q;
    busy_d = (state_d == ST_CALC);
    done_d = (state_d == ST_FIN);
    if (accept) begin
      cnt_d = '0;
      rem_d = '0;
      quo_d = a_mag;
      dvs_d = b_mag;
      if (b_zero) begin
        q_d   = '1;
        r_d   = A;
        dbz_d = 1'b1;
      end
    end else if (state_q == ST_CALC) begin
      cnt_d = cnt_q + CW'(1);
      rem_d = rem_nxt;
      quo_d = raw_q;
      if (cnt_q == LAST) begin
        q_d   = q_fin;
        r_d   = r_fin;
        dbz_d = 1'b0;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider -- directed self-checking bench for seq_divider (WIDTH=32).
// Inputs change and outputs are sampled on the falling edge; "cycle n" is the
// interval after the n-th rising edge following the start request.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] Q, R;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .signed_op  (signed_op),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .Q          (Q),
    .R          (R),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller sits on a falling edge (cycle 0). Returns at the falling edge of
  // the done cycle, or after 40 cycles if done never shows (lat = -1).
  // inj >= 0 pulses start with other operands in that cycle; rst >= 0 pulses
  // reset in that cycle and checks the cleared outputs one cycle later.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int inj, input int rst, output int lat, output int nbusy);
    A = a; B = b; signed_op = s; start = 1'b1;
    lat = -1; nbusy = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      if (busy) nbusy++;
      if (rst >= 0 && n == rst + 1) begin
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_Q", Q, 32'd0);
        chk("rst_R", R, 32'd0);
      end
      if (done) begin
        lat = n;
        break;
      end
      if (n == inj) begin
        A = 32'd9; B = 32'd3; start = 1'b1;
      end
      if (n == rst) reset = 1'b1;
    end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        s;
    logic [31:0] q, r;
  } vec_t;

  initial begin
    int   lat, nb, extra;
    vec_t vt[6];

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_Q", Q, 32'd0);
    chk("reset_R", R, 32'd0);
    chk("reset_dbz", {31'b0, div_by_zero}, 32'd0);
    reset = 1'b0;

    // 100 / 7, then back-to-back 20 / 6 issued in the done cycle.
    run_op(32'd100, 32'd7, 1'b0, -1, -1, lat, nb);
    chk("u100_lat", lat, 32'd33);
    chk("u100_Q", Q, 32'd14);
    chk("u100_R", R, 32'd2);
    chk("u100_dbz", {31'b0, div_by_zero}, 32'd0);
    chk("u100_busy_cycles", nb, 32'd32);
    run_op(32'd20, 32'd6, 1'b0, -1, -1, lat, nb);
    chk("b2b_lat", lat, 32'd33);
    chk("b2b_Q", Q, 32'd3);
    chk("b2b_R", R, 32'd2);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("b2b_Q_hold", Q, 32'd3);

    // Divide by zero.
    run_op(32'd5, 32'd0, 1'b0, -1, -1, lat, nb);
    chk("dz_lat", lat, 32'd1);
    chk("dz_Q", Q, 32'hFFFF_FFFF);
    chk("dz_R", R, 32'd5);
    chk("dz_dbz", {31'b0, div_by_zero}, 32'd1);
    chk("dz_busy_cycles", nb, 32'd0);
    @(negedge clk);

    // Start during CALC is dropped: exactly one done, original result.
    run_op(32'd100, 32'd7, 1'b0, 10, -1, lat, nb);
    chk("inj_lat", lat, 32'd33);
    chk("inj_Q", Q, 32'd14);
    chk("inj_R", R, 32'd2);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("inj_extra_done", extra, 32'd0);

    // Reset mid-CALC aborts; no done through cycle 40; then a clean run.
    run_op(32'd100, 32'd7, 1'b0, -1, 10, lat, nb);
    chk("abort_no_done", lat, 32'hFFFF_FFFF);
    run_op(32'd20, 32'd6, 1'b0, -1, -1, lat, nb);
    chk("after_rst_lat", lat, 32'd33);
    chk("after_rst_Q", Q, 32'd3);
    chk("after_rst_R", R, 32'd2);

    // Reset wins over start in the same cycle.
    @(negedge clk);
    A = 32'd50; B = 32'd7; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    chk("rst_prio_busy", {31'b0, busy}, 32'd0);
    chk("rst_prio_Q", Q, 32'd0);

    // Boundary and sign vectors.
    vt[0] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0};
    vt[1] = '{32'd3, 32'd10, 1'b0, 32'd0, 32'd3};
`ifdef SEQ_DIVIDER_SIGNED_EN
    vt[2] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vt[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0};
    vt[4] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1};
`else
    vt[2] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1};
    vt[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000};
    vt[4] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7};
`endif
    vt[5] = '{32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run_op(vt[i].a, vt[i].b, vt[i].s, -1, -1, lat, nb);
      chk($sformatf("vec%0d_lat", i), lat, 32'd33);
      chk($sformatf("vec%0d_Q", i), Q, vt[i].q);
      chk($sformatf("vec%0d_R", i), R, vt[i].r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
